// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage that sits directly in front of instruction_memory. It owns the
// program counter, presents it as Inst_Address, and latches the returned
// instruction together with its PC into the IF/ID pipeline register.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Instruction  [31:0] combinational read data for the current Inst_Address
//   stall               hold PC and IF/ID (ignored on a redirect edge)
//   branch_taken        redirect request
//   branch_target[63:0] redirect address, bits [1:0] forced to zero
//   Inst_Address [63:0] current PC
//   if_id_pc     [63:0] PC of the instruction in IF/ID
//   if_id_instruction   instruction in IF/ID (NOP_INSTR when not valid)
//   if_id_valid         IF/ID holds a real instruction
//   halted              fetch stopped on an out-of-range PC (FSM in HALT)
//   fetch_count  [63:0] (IFU_PERF_CNT_EN only) normal captures
//   redirect_count[31:0](IFU_PERF_CNT_EN only) accepted branch_taken
//
// Optional feature macro: IFU_PERF_CNT_EN adds the two performance counters.
//
// IF/ID contract: if_id_valid qualifies if_id_pc/if_id_instruction. While
// stall is high (and no redirect) the register holds, so the consumer sees
// the same instruction until stall drops; each instruction is presented
// exactly once per non-stalled cycle.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          PROG_BYTES = 80,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0] fetch_count,
  output logic [31:0] redirect_count,
`endif
  output logic        halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [63:0] PROG_LIMIT = 64'(PROG_BYTES);

  state_t      state;
  logic [63:0] pc;
  logic [63:0] target;
  logic        pc_in_range;
  logic        target_in_range;
  logic        unused_target_bits;

  assign target             = {branch_target[63:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];
  assign pc_in_range        = (pc < PROG_LIMIT);
  assign target_in_range    = (target < PROG_LIMIT);

  assign Inst_Address = pc;
  // state is a register, so this decode is a registered status bit.
  assign halted       = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_RUN;
      pc                <= RESET_PC;
      if_id_pc          <= 64'd0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
`ifdef IFU_PERF_CNT_EN
      fetch_count       <= 64'd0;
      redirect_count    <= 32'd0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            // Flush the wrong-path fetch; if_id_pc keeps its old value.
            pc                <= target;
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
`ifdef IFU_PERF_CNT_EN
            redirect_count    <= redirect_count + 32'd1;
`endif
          end else if (stall) begin
            // Hold everything.
          end else if (pc_in_range) begin
            if_id_pc          <= pc;
            if_id_instruction <= Instruction;
            if_id_valid       <= 1'b1;
            pc                <= pc + 64'd4;
`ifdef IFU_PERF_CNT_EN
            fetch_count       <= fetch_count + 64'd1;
`endif
          end else begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            state             <= ST_HALT;
          end
        end
        ST_HALT: begin
          if_id_valid       <= 1'b0;
          if_id_instruction <= NOP_INSTR;
          if (branch_taken) begin
            // A late backward branch can restart fetch; an out-of-range
            // target just moves the parked PC.
            pc    <= target;
            state <= target_in_range ? ST_RUN : ST_HALT;
`ifdef IFU_PERF_CNT_EN
            redirect_count <= redirect_count + 32'd1;
`endif
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] inst_address;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .Instruction       (instruction),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .Inst_Address      (inst_address),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
`ifdef IFU_PERF_CNT_EN
    .fetch_count       (fetch_count),
    .redirect_count    (redirect_count),
`endif
    .halted            (halted)
  );

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] instr_at(input logic [63:0] a);
    return 32'hC0DE_0000 | a[31:0];
  endfunction

  logic [31:0] mem [0:19];
  always_comb begin
    instruction = 32'hDEAD_BEEF;
    if (inst_address < 64'd80) instruction = mem[inst_address[6:2]];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] exp_pc;
    logic [63:0] exp_if_pc;
    logic [31:0] exp_ins;
    logic        exp_v;
    logic        exp_h;
  } vec_t;

  vec_t vecs [0:63];
  int   n_vecs = 0;

  task automatic add_vec(input logic rst, input logic stl, input logic br,
                         input logic [63:0] tgt, input logic [63:0] pc,
                         input logic [63:0] ipc, input logic [31:0] ins,
                         input logic v, input logic h);
    vecs[n_vecs] = '{rst, stl, br, tgt, pc, ipc, ins, v, h};
    n_vecs++;
  endtask

  task automatic add_normal(input logic [63:0] pc, input logic [63:0] ipc);
    add_vec(0, 0, 0, 64'd0, pc, ipc, instr_at(ipc), 1'b1, 1'b0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic stl, input logic br, input logic [63:0] tgt);
    reset         = rst;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".pc"},      inst_address,              v.exp_pc);
    check({tag, ".if_pc"},   if_id_pc,                  v.exp_if_pc);
    check({tag, ".ins"},     {32'd0, if_id_instruction}, {32'd0, v.exp_ins});
    check({tag, ".valid"},   {63'd0, if_id_valid},      {63'd0, v.exp_v});
    check({tag, ".halted"},  {63'd0, halted},           {63'd0, v.exp_h});
  endtask

  initial begin
    vec_t hv;
    for (int i = 0; i < 20; i++) mem[i] = instr_at(64'(4 * i));

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;

    // Reset, then sequential fetch.
    add_vec(1, 0, 0, 64'd0, 64'd0, 64'd0, NOP, 0, 0);
    for (int k = 1; k <= 3; k++) add_normal(64'(4 * k), 64'(4 * k - 4));
    // Stall three cycles at PC 12.
    for (int k = 0; k < 3; k++) add_vec(0, 1, 0, 64'd0, 64'd12, 64'd8, instr_at(64'd8), 1, 0);
    for (int p = 16; p <= 40; p += 4) add_normal(64'(p), 64'(p - 4));
    // Branch to 0x1B at PC 40 -> 24, flush.
    add_vec(0, 0, 1, 64'h1B, 64'd24, 64'd36, NOP, 0, 0);
    add_normal(64'd28, 64'd24);
    // Stall and branch together: redirect wins.
    add_vec(0, 1, 1, 64'd8, 64'd8, 64'd24, NOP, 0, 0);
    for (int p = 12; p <= 80; p += 4) add_normal(64'(p), 64'(p - 4));
    // PC 80 is out of range: halt.
    add_vec(0, 0, 0, 64'd0, 64'd80, 64'd76, NOP, 0, 1);
    add_vec(0, 1, 0, 64'd0, 64'd80, 64'd76, NOP, 0, 1);
    // Backward branch out of HALT.
    add_vec(0, 0, 1, 64'd8, 64'd8, 64'd76, NOP, 0, 0);
    add_normal(64'd12, 64'd8);
    // Branch to 96 from RUN, then halt there; out-of-range branch stays halted.
    add_vec(0, 0, 1, 64'd96, 64'd96, 64'd8, NOP, 0, 0);
    add_vec(0, 0, 0, 64'd0, 64'd96, 64'd8, NOP, 0, 1);
    add_vec(0, 0, 1, 64'd102, 64'd100, 64'd8, NOP, 0, 1);
    // Restart at 40, capture so PC = 44 with valid = 1.
    add_vec(0, 0, 1, 64'd40, 64'd40, 64'd8, NOP, 0, 0);
    add_normal(64'd44, 64'd40);

    for (int i = 0; i < n_vecs; i++) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt);
      check_outputs($sformatf("v%0d", i), vecs[i]);
    end

    // Hand sequence: reset mid-run with pending stall and branch discarded.
    step(1, 1, 1, 64'd8);
    hv = '{1'b1, 1'b1, 1'b1, 64'd8, 64'd0, 64'd0, NOP, 1'b0, 1'b0};
    check_outputs("rst_mid", hv);
`ifdef IFU_PERF_CNT_EN
    check("rst_mid.fetch_count",    fetch_count,            64'd0);
    check("rst_mid.redirect_count", {32'd0, redirect_count}, 64'd0);
`endif
    step(0, 0, 0, 64'd0);
    hv = '{1'b0, 1'b0, 1'b0, 64'd0, 64'd4, 64'd0, instr_at(64'd0), 1'b1, 1'b0};
    check_outputs("after_rst", hv);
`ifdef IFU_PERF_CNT_EN
    check("after_rst.fetch_count", fetch_count, 64'd1);
    step(0, 0, 1, 64'd16);
    check("redir.redirect_count", {32'd0, redirect_count}, 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
